// File: rtl/sample_buf_pkg.sv
// Shared definitions for the vibration sample buffer: controller state encoding
// and the default geometry that the RAM instance must also use.
package sample_buf_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        OUT     = 3'd4
    } state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// Sample streams around the capture controller: sensor samples in (s_*) and
// read-back samples out to the host link (m_*).
interface capture_ctrl_if
    import sample_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    // s_*: a strobe with no backpressure, s_data is meaningful only while s_valid.
    // m_*: a beat transfers on a rising edge where m_valid && m_ready; once raised,
    // m_valid and m_data hold unchanged until that transfer happens.
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  s_valid,
        input  s_data,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        output s_valid,
        output s_data,
        input  m_valid,
        input  m_data,
        output m_ready
    );

endinterface

// File: rtl/capture_ctrl.sv
// Fills the sample RAM with one frame, then streams it back in address order,
// hiding the RAM read latency behind a registered output stage.
module capture_ctrl
    import sample_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    capture_ctrl_if.master        bus,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_do,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output state_t                state
);

    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic                  draining;

    assign draining = (state == RD_REQ) || (state == RD_WAIT) || (state == OUT);

    // Writes are zero-latency: the strobe itself drives the RAM write port.
    always_comb begin
        ram_we     = (state == CAPTURE) && bus.s_valid;
        ram_en     = ram_we || (state == RD_REQ);
        ram_w_addr = wr_cnt;
        ram_r_addr = rd_cnt;
        ram_di     = bus.s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (draining && bus.s_valid) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CAPTURE;
                        wr_cnt  <= '0;
                        overrun <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (bus.s_valid) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST) begin
                            state  <= RD_REQ;
                            rd_cnt <= '0;
                        end
                    end
                end
                RD_REQ: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    bus.m_data  <= ram_do;
                    bus.m_valid <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (bus.m_ready) begin
                        bus.m_valid <= 1'b0;
                        if (rd_cnt == LAST) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                            state  <= RD_REQ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a behavioural full-duplex sample RAM beside it.
module tb_capture_ctrl;
    import sample_buf_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_w_addr;
    logic [DW-1:0] ram_di;
    logic [AW-1:0] ram_r_addr;
    logic [DW-1:0] ram_do;
    logic          busy;
    logic          done;
    logic          overrun;
    state_t        dbg_state;

    capture_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_w_addr] <= ram_di;
            ram_do <= mem[ram_r_addr];
        end
    end

    capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_w_addr (ram_w_addr),
        .ram_di     (ram_di),
        .ram_r_addr (ram_r_addr),
        .ram_do     (ram_do),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .state      (dbg_state)
    );

    typedef struct {
        int            gap;
        int            rdy_div;
        logic [DW-1:0] base;
        logic [DW-1:0] step;
        bit            poke;
        int            extra;
        bit            exp_overrun;
    } vec_t;

    vec_t          vecs [4];
    logic [DW-1:0] exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        int            cyc;
        int            beats;
        int            last_hs;
        logic          vv;
        logic          hs;
        logic [DW-1:0] dd;
        logic [DW-1:0] exp_d;

        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("overrun_cleared_by_start", overrun, 0);

        for (int i = 0; i < DEPTH + v.extra; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = v.base + DW'(v.step * i);
            if (i < DEPTH) exp_q.push_back(bus.s_data);
            start = v.poke && (i == 5);
            tick;
            bus.s_valid = 1'b0;
            start       = 1'b0;
            if (i == DEPTH) chk("overrun_after_17th", overrun, 1);
            repeat (v.gap) tick;
        end
        chk("overrun_flag", overrun, v.exp_overrun);

        cyc     = 0;
        beats   = 0;
        last_hs = -1;
        while (beats < DEPTH && cyc < 2000) begin
            bus.m_ready = ((cyc % v.rdy_div) == 0);
            start       = v.poke && (cyc == 2);
            vv          = bus.m_valid;
            dd          = bus.m_data;
            hs          = vv && bus.m_ready;
            chk("ram_we_low_while_draining", ram_we, 0);
            tick;
            start = 1'b0;
            if (hs) begin
                exp_d = exp_q.pop_front();
                chk("m_data", dd, exp_d);
                if (v.rdy_div == 1 && last_hs >= 0) chk("beat_interval", cyc - last_hs, 3);
                if (v.rdy_div == 1 && v.gap == 0 && v.extra == 0 && last_hs < 0)
                    chk("first_beat_latency", cyc, 2);
                last_hs = cyc;
                beats++;
                chk("done", done, beats == DEPTH);
                chk("busy", busy, beats != DEPTH);
            end else if (vv) begin
                chk("m_valid_held", bus.m_valid, 1);
                chk("m_data_held", bus.m_data, dd);
            end
            cyc++;
        end
        bus.m_ready = 1'b0;
        if (beats < DEPTH) chk("read_timeout_beats", beats, DEPTH);
        tick;
        chk("done_single_pulse", done, 0);
        chk("idle_after_frame", dbg_state, IDLE);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   beats;
        int   cyc;
        vec_t v_a0;

        vecs[0] = '{gap: 0, rdy_div: 1, base: 8'h00, step: 8'h01, poke: 0, extra: 0, exp_overrun: 0};
        vecs[1] = '{gap: 2, rdy_div: 4, base: 8'h30, step: 8'h03, poke: 0, extra: 0, exp_overrun: 0};
        vecs[2] = '{gap: 0, rdy_div: 1, base: 8'h80, step: 8'h01, poke: 0, extra: 4, exp_overrun: 1};
        vecs[3] = '{gap: 1, rdy_div: 2, base: 8'hF0, step: 8'h07, poke: 1, extra: 0, exp_overrun: 0};
        v_a0    = '{gap: 0, rdy_div: 1, base: 8'hA0, step: 8'h01, poke: 0, extra: 0, exp_overrun: 0};

        // Reset with start held: reset must win.
        rst         = 1'b1;
        start       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        repeat (3) tick;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, IDLE);
        chk("rst_ram_en", ram_en, 0);
        rst   = 1'b0;
        start = 1'b0;
        tick;
        chk("idle_after_rst_busy", busy, 0);

        bus.s_valid = 1'b1;
        bus.s_data  = 8'h5A;
        chk("idle_ram_we", ram_we, 0);
        tick;
        bus.s_valid = 1'b0;
        chk("idle_s_valid_no_overrun", overrun, 0);
        chk("idle_s_valid_stays_idle", dbg_state, IDLE);

        for (int k = 0; k < 4; k++) begin
            exp_q.delete();
            run_frame(vecs[k]);
        end

        // Reset while OUT holds the beat at rd_cnt 7.
        exp_q.delete();
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DW'(i * 5);
            tick;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        beats       = 0;
        cyc         = 0;
        while (beats < 7 && cyc < 200) begin
            if (bus.m_valid) beats++;
            tick;
            cyc++;
        end
        bus.m_ready = 1'b0;
        while (!bus.m_valid && cyc < 200) begin
            tick;
            cyc++;
        end
        chk("midrst_beats_before", beats, 7);
        chk("midrst_in_out", dbg_state, OUT);
        chk("midrst_read_addr", ram_r_addr, 7);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_m_valid", bus.m_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_state", dbg_state, IDLE);
        tick;
        chk("midrst_no_late_done", done, 0);
        run_frame(v_a0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
